// File: rtl/usb_pump_scheduler.sv
// Round-robin arbiter sharing one USB transceiver pumper among N_REQ producers.
// Grants one requester, waits for FIFO space, runs one burst, and ends it on completion or watchdog.
module usb_pump_scheduler #(
  parameter int unsigned N_REQ   = 4,
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned GAP     = 2
) (
  input  logic               CLK,
  input  logic               NRST,
  input  logic [N_REQ-1:0]   REQ,
  input  logic [8*N_REQ-1:0] ADDR,
  input  logic               TXE_N,
  input  logic               PUMP_COMPLT,
  output logic               PUMP_ENA,
  output logic [7:0]         PUMP_RADDR_START,
  output logic [N_REQ-1:0]   GNT,
  output logic [N_REQ-1:0]   ACK,
  output logic               TOUT,
  output logic               BUSY
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam int unsigned PW = $clog2(N_REQ);
  localparam int unsigned GW = $clog2(GAP + 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT_TXE, S_PUMP, S_GAP} state_t;

  state_t            state, state_n;
  logic [TW-1:0]     timer, timer_n;
  logic [GW-1:0]     gap_cnt, gap_n;
  logic [PW-1:0]     ptr, ptr_n;
  logic [PW-1:0]     win_idx, cand;
  logic              ena_n, tout_n, busy_n;
  logic [7:0]        addr_n;
  logic [N_REQ-1:0]  gnt_n, ack_n;

  // Scan downward so the nearest requester after the pointer is the last one assigned.
  always_comb begin
    win_idx = ptr;
    cand    = '0;
    for (int unsigned i = N_REQ; i >= 1; i--) begin
      cand = PW'((32'(ptr) + i) % N_REQ);
      if (REQ[cand]) win_idx = cand;
    end
  end

  always_comb begin
    state_n = state;
    timer_n = timer;
    gap_n   = gap_cnt;
    ptr_n   = ptr;
    ena_n   = PUMP_ENA;
    addr_n  = PUMP_RADDR_START;
    gnt_n   = GNT;
    ack_n   = '0;
    tout_n  = 1'b0;
    case (state)
      S_IDLE: begin
        if (|REQ) begin
          gnt_n          = '0;
          gnt_n[win_idx] = 1'b1;
          addr_n         = ADDR[{win_idx, 3'b000} +: 8];
          ptr_n          = win_idx;
          timer_n        = '0;
          state_n        = S_WAIT_TXE;
        end
      end
      S_WAIT_TXE, S_PUMP: begin
        // Completion outranks a watchdog expiry landing on the same edge.
        if (state == S_PUMP && PUMP_COMPLT) begin
          ena_n   = 1'b0;
          gnt_n   = '0;
          ack_n   = GNT;
          gap_n   = '0;
          state_n = S_GAP;
        end else if (timer == TW'(TIMEOUT - 1)) begin
          ena_n   = 1'b0;
          gnt_n   = '0;
          tout_n  = 1'b1;
          gap_n   = '0;
          state_n = S_GAP;
        end else begin
          if (timer != '1) timer_n = timer + 1'b1;
          if (state == S_WAIT_TXE && !TXE_N) begin
            ena_n   = 1'b1;
            state_n = S_PUMP;
          end
        end
      end
      S_GAP: begin
        if (gap_cnt == GW'(GAP - 1)) state_n = S_IDLE;
        else                         gap_n   = gap_cnt + 1'b1;
      end
      default: state_n = S_IDLE;
    endcase
    busy_n = (state_n != S_IDLE);
  end

  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      state            <= S_IDLE;
      timer            <= '0;
      gap_cnt          <= '0;
      ptr              <= PW'(N_REQ - 1);
      PUMP_ENA         <= 1'b0;
      PUMP_RADDR_START <= '0;
      GNT              <= '0;
      ACK              <= '0;
      TOUT             <= 1'b0;
      BUSY             <= 1'b0;
    end else begin
      state            <= state_n;
      timer            <= timer_n;
      gap_cnt          <= gap_n;
      ptr              <= ptr_n;
      PUMP_ENA         <= ena_n;
      PUMP_RADDR_START <= addr_n;
      GNT              <= gnt_n;
      ACK              <= ack_n;
      TOUT             <= tout_n;
      BUSY             <= busy_n;
    end
  end

endmodule

// File: tb/tb_usb_pump_scheduler.sv
// Directed bench for usb_pump_scheduler with a pumper model raising COMPLT a set number of cycles after enable.
module tb_usb_pump_scheduler;

  logic        CLK = 1'b0;
  logic        NRST = 1'b1;
  logic [3:0]  REQ = '0;
  logic [31:0] ADDR = '0;
  logic        TXE_N = 1'b0;
  logic        PUMP_COMPLT = 1'b0;
  logic        PUMP_ENA;
  logic [7:0]  PUMP_RADDR_START;
  logic [3:0]  GNT;
  logic [3:0]  ACK;
  logic        TOUT;
  logic        BUSY;

  int vec = 0;
  int miss = 0;
  int cmpl_delay = 131;
  int pc = 0;

  usb_pump_scheduler #(.N_REQ(4), .TIMEOUT(255), .GAP(2)) dut (
    .CLK(CLK), .NRST(NRST), .REQ(REQ), .ADDR(ADDR), .TXE_N(TXE_N),
    .PUMP_COMPLT(PUMP_COMPLT), .PUMP_ENA(PUMP_ENA), .PUMP_RADDR_START(PUMP_RADDR_START),
    .GNT(GNT), .ACK(ACK), .TOUT(TOUT), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  // Pumper model: COMPLT changes on the falling edge, cmpl_delay falling edges after enable rises.
  always @(negedge CLK or negedge NRST) begin
    if (!NRST) begin
      pc = 0;
      PUMP_COMPLT = 1'b0;
    end else if (PUMP_ENA) begin
      pc = pc + 1;
      if (pc >= cmpl_delay) PUMP_COMPLT = 1'b1;
    end else begin
      pc = 0;
      PUMP_COMPLT = 1'b0;
    end
  end

  task automatic tick();
    @(negedge CLK);
  endtask

  task automatic test_reset();
    #1 NRST = 1'b0;
    tick(); tick();
    vec++; if (PUMP_ENA !== 1'b0) begin miss++; $display("FAIL rst_ena: got %b expected 0", PUMP_ENA); end
    vec++; if (PUMP_RADDR_START !== 8'h00) begin miss++; $display("FAIL rst_addr: got %h expected 00", PUMP_RADDR_START); end
    vec++; if (GNT !== 4'b0000) begin miss++; $display("FAIL rst_gnt: got %b expected 0000", GNT); end
    vec++; if (ACK !== 4'b0000) begin miss++; $display("FAIL rst_ack: got %b expected 0000", ACK); end
    vec++; if (TOUT !== 1'b0) begin miss++; $display("FAIL rst_tout: got %b expected 0", TOUT); end
    vec++; if (BUSY !== 1'b0) begin miss++; $display("FAIL rst_busy: got %b expected 0", BUSY); end
    NRST = 1'b1;
    tick();
  endtask

  task automatic test_single();
    int n;
    ADDR = {8'h33, 8'h22, 8'h11, 8'h40};
    TXE_N = 1'b0;
    REQ = 4'b0001;
    tick();
    vec++; if (GNT !== 4'b0001) begin miss++; $display("FAIL single_gnt: got %b expected 0001", GNT); end
    vec++; if (PUMP_RADDR_START !== 8'h40) begin miss++; $display("FAIL single_addr: got %h expected 40", PUMP_RADDR_START); end
    vec++; if (PUMP_ENA !== 1'b0) begin miss++; $display("FAIL single_ena_early: got %b expected 0", PUMP_ENA); end
    vec++; if (BUSY !== 1'b1) begin miss++; $display("FAIL single_busy: got %b expected 1", BUSY); end
    ADDR[7:0] = 8'h55;
    tick();
    vec++; if (PUMP_ENA !== 1'b1) begin miss++; $display("FAIL single_ena: got %b expected 1", PUMP_ENA); end
    vec++; if (PUMP_RADDR_START !== 8'h40) begin miss++; $display("FAIL single_addr_hold: got %h expected 40", PUMP_RADDR_START); end
    n = 0;
    while (ACK === 4'b0000 && n < 400) begin tick(); n++; end
    vec++; if (n !== 131) begin miss++; $display("FAIL single_burst_len: got %0d expected 131", n); end
    vec++; if (ACK !== 4'b0001) begin miss++; $display("FAIL single_ack: got %b expected 0001", ACK); end
    vec++; if (GNT !== 4'b0000) begin miss++; $display("FAIL single_gnt_clr: got %b expected 0000", GNT); end
    vec++; if (PUMP_ENA !== 1'b0) begin miss++; $display("FAIL single_ena_fall: got %b expected 0", PUMP_ENA); end
    REQ = 4'b0000;
    tick();
    vec++; if (ACK !== 4'b0000) begin miss++; $display("FAIL single_ack_pulse: got %b expected 0000", ACK); end
    vec++; if (PUMP_ENA !== 1'b0 || BUSY !== 1'b1) begin miss++; $display("FAIL single_gap1: got ena=%b busy=%b expected ena=0 busy=1", PUMP_ENA, BUSY); end
    tick();
    vec++; if (PUMP_ENA !== 1'b0 || BUSY !== 1'b0) begin miss++; $display("FAIL single_idle: got ena=%b busy=%b expected ena=0 busy=0", PUMP_ENA, BUSY); end
  endtask

  task automatic test_round_robin();
    int n;
    logic [3:0] exp_g;
    logic [7:0] exp_a;
    NRST = 1'b0; tick(); NRST = 1'b1; tick();
    ADDR = {8'h40, 8'h30, 8'h20, 8'h10};
    TXE_N = 1'b0;
    REQ = 4'b1111;
    for (int r = 0; r < 5; r++) begin
      exp_g = 4'b0001 << (r % 4);
      exp_a = 8'h10 * 8'((r % 4) + 1);
      n = 0;
      do begin tick(); n++; end while (GNT === 4'b0000 && n < 400);
      vec++; if (n !== ((r == 0) ? 1 : 3)) begin miss++; $display("FAIL rr_spacing%0d: got %0d expected %0d", r, n, (r == 0) ? 1 : 3); end
      vec++; if (GNT !== exp_g) begin miss++; $display("FAIL rr_gnt%0d: got %b expected %b", r, GNT, exp_g); end
      vec++; if (PUMP_RADDR_START !== exp_a) begin miss++; $display("FAIL rr_addr%0d: got %h expected %h", r, PUMP_RADDR_START, exp_a); end
      vec++; if (PUMP_ENA !== 1'b0) begin miss++; $display("FAIL rr_overlap%0d: got ena=%b expected 0", r, PUMP_ENA); end
      n = 0;
      while (ACK === 4'b0000 && n < 400) begin tick(); n++; end
      vec++; if (ACK !== exp_g || GNT !== 4'b0000) begin miss++; $display("FAIL rr_ack%0d: got ack=%b gnt=%b expected ack=%b gnt=0000", r, ACK, GNT, exp_g); end
    end
    REQ = 4'b0000;
    n = 0;
    while (BUSY !== 1'b0 && n < 20) begin tick(); n++; end
    vec++; if (BUSY !== 1'b0) begin miss++; $display("FAIL rr_idle: got %b expected 0", BUSY); end
  endtask

  task automatic test_txe_wait();
    int n;
    logic ena_seen;
    ADDR = {8'h40, 8'h30, 8'h81, 8'h10};
    TXE_N = 1'b1;
    REQ = 4'b0010;
    tick();
    vec++; if (GNT !== 4'b0010) begin miss++; $display("FAIL txe_gnt: got %b expected 0010", GNT); end
    ena_seen = 1'b0;
    for (int i = 0; i < 50; i++) begin tick(); if (PUMP_ENA !== 1'b0) ena_seen = 1'b1; end
    vec++; if (ena_seen !== 1'b0) begin miss++; $display("FAIL txe_hold: got ena_seen=%b expected 0", ena_seen); end
    TXE_N = 1'b0;
    tick();
    vec++; if (PUMP_ENA !== 1'b1) begin miss++; $display("FAIL txe_ena: got %b expected 1", PUMP_ENA); end
    vec++; if (PUMP_RADDR_START !== 8'h81) begin miss++; $display("FAIL txe_addr: got %h expected 81", PUMP_RADDR_START); end
    n = 0;
    while (ACK === 4'b0000 && n < 400) begin tick(); n++; end
    vec++; if (n !== 131 || ACK !== 4'b0010) begin miss++; $display("FAIL txe_ack: got n=%0d ack=%b expected n=131 ack=0010", n, ACK); end
    REQ = 4'b0000;
    n = 0;
    while (BUSY !== 1'b0 && n < 20) begin tick(); n++; end
    vec++; if (BUSY !== 1'b0) begin miss++; $display("FAIL txe_idle: got %b expected 0", BUSY); end
  endtask

  task automatic test_timeout();
    int n;
    logic ack_seen;
    ADDR = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
    TXE_N = 1'b1;
    REQ = 4'b1100;
    tick();
    vec++; if (GNT !== 4'b0100) begin miss++; $display("FAIL to_gnt: got %b expected 0100", GNT); end
    n = 0;
    ack_seen = 1'b0;
    while (TOUT === 1'b0 && n < 400) begin tick(); n++; if (ACK !== 4'b0000) ack_seen = 1'b1; end
    vec++; if (n !== 255) begin miss++; $display("FAIL to_cycle: got %0d expected 255", n); end
    vec++; if (TOUT !== 1'b1 || GNT !== 4'b0000 || PUMP_ENA !== 1'b0) begin miss++; $display("FAIL to_abort: got tout=%b gnt=%b ena=%b expected 1 0000 0", TOUT, GNT, PUMP_ENA); end
    vec++; if (ack_seen !== 1'b0) begin miss++; $display("FAIL to_noack: got ack_seen=%b expected 0", ack_seen); end
    REQ = 4'b1000;
    TXE_N = 1'b0;
    tick();
    vec++; if (TOUT !== 1'b0) begin miss++; $display("FAIL to_pulse: got %b expected 0", TOUT); end
    n = 1;
    while (GNT === 4'b0000 && n < 20) begin tick(); n++; end
    vec++; if (n !== 3 || GNT !== 4'b1000) begin miss++; $display("FAIL to_next: got n=%0d gnt=%b expected n=3 gnt=1000", n, GNT); end
    vec++; if (PUMP_RADDR_START !== 8'hD3) begin miss++; $display("FAIL to_next_addr: got %h expected d3", PUMP_RADDR_START); end
    n = 0;
    while (ACK === 4'b0000 && n < 400) begin tick(); n++; end
    vec++; if (ACK !== 4'b1000 || TOUT !== 1'b0) begin miss++; $display("FAIL to_next_ack: got ack=%b tout=%b expected 1000 0", ACK, TOUT); end
    REQ = 4'b0000;
    n = 0;
    while (BUSY !== 1'b0 && n < 20) begin tick(); n++; end
    vec++; if (BUSY !== 1'b0) begin miss++; $display("FAIL to_idle: got %b expected 0", BUSY); end
  endtask

  task automatic test_coincide();
    int n;
    TXE_N = 1'b0;
    cmpl_delay = 254;
    REQ = 4'b0001;
    tick();
    vec++; if (GNT !== 4'b0001) begin miss++; $display("FAIL co_gnt: got %b expected 0001", GNT); end
    n = 0;
    while (ACK === 4'b0000 && TOUT === 1'b0 && n < 400) begin tick(); n++; end
    vec++; if (n !== 255) begin miss++; $display("FAIL co_cycle: got %0d expected 255", n); end
    vec++; if (ACK !== 4'b0001 || TOUT !== 1'b0) begin miss++; $display("FAIL co_winner: got ack=%b tout=%b expected 0001 0", ACK, TOUT); end
    REQ = 4'b0000;
    tick();
    vec++; if (TOUT !== 1'b0 || ACK !== 4'b0000) begin miss++; $display("FAIL co_after: got tout=%b ack=%b expected 0 0000", TOUT, ACK); end
    cmpl_delay = 131;
    n = 0;
    while (BUSY !== 1'b0 && n < 20) begin tick(); n++; end
    vec++; if (BUSY !== 1'b0) begin miss++; $display("FAIL co_idle: got %b expected 0", BUSY); end
  endtask

  task automatic test_reset_mid();
    int n;
    TXE_N = 1'b0;
    REQ = 4'b0100;
    tick();
    vec++; if (GNT !== 4'b0100) begin miss++; $display("FAIL rm_gnt: got %b expected 0100", GNT); end
    tick();
    vec++; if (PUMP_ENA !== 1'b1) begin miss++; $display("FAIL rm_ena: got %b expected 1", PUMP_ENA); end
    for (int i = 0; i < 10; i++) tick();
    #2 NRST = 1'b0;
    #1;
    vec++; if (PUMP_ENA !== 1'b0 || GNT !== 4'b0000 || BUSY !== 1'b0) begin miss++; $display("FAIL rm_async: got ena=%b gnt=%b busy=%b expected 0 0000 0", PUMP_ENA, GNT, BUSY); end
    vec++; if (ACK !== 4'b0000 || TOUT !== 1'b0) begin miss++; $display("FAIL rm_nopulse: got ack=%b tout=%b expected 0000 0", ACK, TOUT); end
    REQ = 4'b0101;
    tick();
    NRST = 1'b1;
    tick();
    vec++; if (GNT !== 4'b0001) begin miss++; $display("FAIL rm_first: got %b expected 0001", GNT); end
    REQ = 4'b0000;
    n = 0;
    while (ACK === 4'b0000 && n < 400) begin tick(); n++; end
    vec++; if (n !== 132 || ACK !== 4'b0001) begin miss++; $display("FAIL rm_dropreq_ack: got n=%0d ack=%b expected n=132 ack=0001", n, ACK); end
    n = 0;
    while (BUSY !== 1'b0 && n < 20) begin tick(); n++; end
    vec++; if (BUSY !== 1'b0) begin miss++; $display("FAIL rm_idle: got %b expected 0", BUSY); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_txe_wait();
    test_timeout();
    test_coincide();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule
